// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: walks each instruction through fetch, decode, execute,
// memory and writeback, driving datapath enables and tracking halt/illegal/retire status.
module cpu_ctrl_fsm #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_src_imm,
    output logic             imm_zero_ext,
    output logic [2:0]       alu_op,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_o
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h01;
    localparam logic [5:0] OpAndi  = 6'h02;
    localparam logic [5:0] OpOri   = 6'h03;
    localparam logic [5:0] OpLw    = 6'h04;
    localparam logic [5:0] OpSw    = 6'h05;
    localparam logic [5:0] OpBeq   = 6'h06;
    localparam logic [5:0] OpHalt  = 6'h3F;

    localparam logic [1:0] PcSeq    = 2'd0;
    localparam logic [1:0] PcBranch = 2'd1;
    localparam logic [1:0] PcHold   = 2'd2;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5,
        StError  = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [5:0]       opcode_q, opcode_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // Operand controls decoded from the latched opcode
    logic       dec_src_imm;
    logic       dec_zero_ext;
    logic [2:0] dec_alu_op;

    always_comb begin
        dec_src_imm  = 1'b0;
        dec_zero_ext = 1'b0;
        dec_alu_op   = 3'd0;
        unique case (opcode_q)
            OpRtype: dec_alu_op = 3'd7;
            OpAddi:  dec_src_imm = 1'b1;
            OpAndi: begin
                dec_src_imm  = 1'b1;
                dec_zero_ext = 1'b1;
                dec_alu_op   = 3'd2;
            end
            OpOri: begin
                dec_src_imm  = 1'b1;
                dec_zero_ext = 1'b1;
                dec_alu_op   = 3'd3;
            end
            OpLw, OpSw: dec_src_imm = 1'b1;
            OpBeq:   dec_alu_op = 3'd1;
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        halted_d     = halted_q;
        illegal_d    = illegal_q;
        retired_d    = retired_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PcHold;
        alu_src_imm  = 1'b0;
        imm_zero_ext = 1'b0;
        alu_op       = 3'd0;
        reg_we       = 1'b0;
        wb_sel       = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_src  = PcSeq;
                    state_d = StDecode;
                end else if (wait_q == WaitLast) begin
                    illegal_d = 1'b1;
                    state_d   = StError;
                end
            end
            StDecode: begin
                opcode_d = opcode;
                if (opcode <= OpBeq) begin
                    state_d = StExec;
                end else if (opcode == OpHalt) begin
                    halted_d = 1'b1;
                    state_d  = StHalt;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StError;
                end
            end
            StExec: begin
                alu_op       = dec_alu_op;
                alu_src_imm  = dec_src_imm;
                imm_zero_ext = dec_zero_ext;
                if (opcode_q == OpBeq) begin
                    if (alu_zero) begin
                        pc_we  = 1'b1;
                        pc_src = PcBranch;
                    end
                    retired_d = retired_q + 1'b1;
                    state_d   = StFetch;
                end else if (opcode_q == OpLw || opcode_q == OpSw) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                alu_src_imm  = dec_src_imm;
                imm_zero_ext = dec_zero_ext;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode_q == OpSw);
                if (mem_ready) begin
                    if (opcode_q == OpSw) begin
                        retired_d = retired_q + 1'b1;
                        state_d   = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_q == WaitLast) begin
                    illegal_d = 1'b1;
                    state_d   = StError;
                end
            end
            StWb: begin
                alu_src_imm  = dec_src_imm;
                imm_zero_ext = dec_zero_ext;
                reg_we       = 1'b1;
                wb_sel       = (opcode_q == OpLw);
                retired_d    = retired_q + 1'b1;
                state_d      = StFetch;
            end
            StHalt, StError: ;
            default: begin
                illegal_d = 1'b1;
                state_d   = StError;
            end
        endcase

        // Bus wait counter restarts whenever the state changes
        if (state_d == state_q && (state_q == StFetch || state_q == StMem)) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = '0;
        end

        // Suppress every write while reset is asserted so an aborted instruction leaves no trace
        if (!rst_n) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            pc_src       = PcHold;
            alu_src_imm  = 1'b0;
            imm_zero_ext = 1'b0;
            alu_op       = 3'd0;
            reg_we       = 1'b0;
            wb_sel       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            opcode_q  <= 6'h00;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            opcode_q  <= opcode_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign retired = retired_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed self-checking bench for cpu_ctrl_fsm; inputs change and outputs are checked
// just after the falling edge.
module tb_cpu_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        alu_src_imm;
    logic        imm_zero_ext;
    logic [2:0]  alu_op;
    logic        reg_we;
    logic        wb_sel;
    logic        halted;
    logic        illegal;
    logic [31:0] retired;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    cpu_ctrl_fsm #(
        .CNT_W  (32),
        .TIMEOUT(8)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .alu_zero    (alu_zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr_sel(mem_addr_sel),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .alu_src_imm (alu_src_imm),
        .imm_zero_ext(imm_zero_ext),
        .alu_op      (alu_op),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .halted      (halted),
        .illegal     (illegal),
        .retired     (retired),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle and apply inputs for it
    task automatic cyc(input logic rdy, input logic az);
        @(negedge clk);
        mem_ready = rdy;
        alu_zero  = az;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic release_reset(input logic rdy);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; opcode = 6'h00; alu_zero = 1'b0; mem_ready = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_state", state_o, 0);
        check_eq("rst_retired", retired, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_illegal", illegal, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_pc_src", pc_src, 2);

        // ADDI, zero wait states
        opcode = 6'h01;
        release_reset(1'b1);
        check_eq("addi_c0_state", state_o, 0);
        check_eq("addi_c0_ir_we", ir_we, 1);
        check_eq("addi_c0_pc_we", pc_we, 1);
        check_eq("addi_c0_pc_src", pc_src, 0);
        check_eq("addi_c0_addr_sel", mem_addr_sel, 0);
        cyc(1'b1, 1'b0);
        check_eq("addi_c1_state", state_o, 1);
        check_eq("addi_c1_ir_we", ir_we, 0);
        check_eq("addi_c1_pc_src", pc_src, 2);
        cyc(1'b1, 1'b0);
        check_eq("addi_c2_state", state_o, 2);
        check_eq("addi_c2_alu_op", alu_op, 0);
        check_eq("addi_c2_src_imm", alu_src_imm, 1);
        check_eq("addi_c2_zext", imm_zero_ext, 0);
        check_eq("addi_c2_reg_we", reg_we, 0);
        cyc(1'b1, 1'b0);
        check_eq("addi_c3_state", state_o, 4);
        check_eq("addi_c3_reg_we", reg_we, 1);
        check_eq("addi_c3_wb_sel", wb_sel, 0);
        check_eq("addi_c3_src_imm", alu_src_imm, 1);
        check_eq("addi_c3_retired", retired, 0);

        // LW with 3 wait cycles in FETCH and MEM
        opcode = 6'h04;
        cyc(1'b0, 1'b0);
        check_eq("addi_retired", retired, 1);
        check_eq("lw_f_state", state_o, 0);
        check_eq("lw_f_req0", mem_req, 1);
        check_eq("lw_f_ir0", ir_we, 0);
        cyc(1'b0, 1'b0);
        check_eq("lw_f_req1", mem_req, 1);
        cyc(1'b0, 1'b0);
        check_eq("lw_f_req2", mem_req, 1);
        check_eq("lw_f_pc_src2", pc_src, 2);
        cyc(1'b1, 1'b0);
        check_eq("lw_f_state3", state_o, 0);
        check_eq("lw_f_ir3", ir_we, 1);
        cyc(1'b1, 1'b0);
        check_eq("lw_dec_state", state_o, 1);
        cyc(1'b0, 1'b0);
        check_eq("lw_exec_state", state_o, 2);
        check_eq("lw_exec_alu_op", alu_op, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0);
            check_eq("lw_mem_state", state_o, 3);
            check_eq("lw_mem_req", mem_req, 1);
            check_eq("lw_mem_addr_sel", mem_addr_sel, 1);
            check_eq("lw_mem_we", mem_we, 0);
        end
        cyc(1'b1, 1'b0);
        check_eq("lw_mem_state3", state_o, 3);
        check_eq("lw_mem_req3", mem_req, 1);
        cyc(1'b1, 1'b0);
        check_eq("lw_wb_state", state_o, 4);
        check_eq("lw_wb_reg_we", reg_we, 1);
        check_eq("lw_wb_sel", wb_sel, 1);

        // BEQ taken, then BEQ not taken
        opcode = 6'h06;
        cyc(1'b1, 1'b0);
        check_eq("lw_retired", retired, 2);
        check_eq("beq1_f_state", state_o, 0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        check_eq("beq1_exec_state", state_o, 2);
        check_eq("beq1_pc_we", pc_we, 1);
        check_eq("beq1_pc_src", pc_src, 1);
        check_eq("beq1_alu_op", alu_op, 1);
        check_eq("beq1_src_imm", alu_src_imm, 0);
        cyc(1'b1, 1'b0);
        check_eq("beq1_retired", retired, 3);
        check_eq("beq2_f_state", state_o, 0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        check_eq("beq2_exec_state", state_o, 2);
        check_eq("beq2_pc_we", pc_we, 0);
        check_eq("beq2_pc_src", pc_src, 2);

        // ORI, then an undefined opcode
        opcode = 6'h03;
        cyc(1'b1, 1'b0);
        check_eq("beq2_retired", retired, 4);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        check_eq("ori_exec_alu_op", alu_op, 3);
        check_eq("ori_exec_zext", imm_zero_ext, 1);
        check_eq("ori_exec_src_imm", alu_src_imm, 1);
        cyc(1'b1, 1'b0);
        check_eq("ori_wb_zext", imm_zero_ext, 1);
        check_eq("ori_wb_reg_we", reg_we, 1);
        opcode = 6'h2A;
        cyc(1'b1, 1'b0);
        check_eq("ori_retired", retired, 5);
        cyc(1'b1, 1'b0);
        check_eq("ill_dec_state", state_o, 1);
        check_eq("ill_dec_flag", illegal, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1);
            check_eq("ill_state", state_o, 6);
            check_eq("ill_flag", illegal, 1);
            check_eq("ill_mem_req", mem_req, 0);
            check_eq("ill_pc_src", pc_src, 2);
            check_eq("ill_retired", retired, 5);
        end

        // SW aborted by reset during MEM, then HALT
        do_reset();
        check_eq("sw_rst_illegal", illegal, 0);
        opcode = 6'h05;
        release_reset(1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check_eq("sw_exec_state", state_o, 2);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0);
            check_eq("sw_mem_state", state_o, 3);
            check_eq("sw_mem_we", mem_we, 1);
            check_eq("sw_mem_addr_sel", mem_addr_sel, 1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_eq("sw_abort_mem_we", mem_we, 0);
        check_eq("sw_abort_reg_we", reg_we, 0);
        opcode = 6'h3F;
        release_reset(1'b1);
        check_eq("sw_post_state", state_o, 0);
        check_eq("sw_post_retired", retired, 0);
        check_eq("sw_post_illegal", illegal, 0);
        check_eq("sw_post_reg_we", reg_we, 0);
        cyc(1'b1, 1'b0);
        check_eq("halt_dec_state", state_o, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0);
            check_eq("halt_state", state_o, 5);
            check_eq("halt_flag", halted, 1);
            check_eq("halt_retired", retired, 0);
            check_eq("halt_mem_req", mem_req, 0);
        end

        // Fetch timeout with mem_ready never asserted
        do_reset();
        check_eq("to_rst_halted", halted, 0);
        release_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc(1'b0, 1'b0);
            check_eq("to_fetch_state", state_o, 0);
            check_eq("to_fetch_ir_we", ir_we, 0);
            check_eq("to_fetch_illegal", illegal, 0);
        end
        cyc(1'b0, 1'b0);
        check_eq("to_state", state_o, 6);
        check_eq("to_illegal", illegal, 1);
        check_eq("to_ir_we", ir_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
